// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: load/store funct3 encodings and MEM-stage FSM states.
package riscv_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword out of a read word and sign/zero extends it.
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select by low address bits, then extend by access type
  always_comb begin
    w_byte   = 8'h00;
    w_half   = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_result = i_rdata;
    case (i_addr)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    case (i_funct3)
      LB:      o_result = {{24{w_byte[7]}}, w_byte};
      LH:      o_result = {{16{w_half[15]}}, w_half};
      LBU:     o_result = {24'h0, w_byte};
      LHU:     o_result = {16'h0, w_half};
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: pass-through for ALU ops, req/ack data-memory access for
// loads/stores with alignment checks, store lanes, load extension and timeout.
module mem_access_stage
  import riscv_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_flag_i,
  input  logic        wb_en_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [2:0]  funct3_i,
  output logic        stall_o,
  output logic        s_flag_o,
  output logic        wb_en_o,
  output logic [4:0]  rd_o,
  output logic [31:0] result_o,
  output logic        fault_o,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

  mem_state_t  r_state;
  logic [4:0]  r_rd;
  logic [31:0] r_addr;
  logic [2:0]  r_f3;
  logic        r_we;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic [15:0] r_cnt;
  logic        r_timeout;
  logic [31:0] r_result;

  logic        w_mem, w_ld_ok, w_st_ok, w_illegal, w_misalign, w_bad, w_start;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_ext;

  load_extend u_ext (
    .i_rdata  (dmem_rdata),
    .i_addr   (r_addr[1:0]),
    .i_funct3 (r_f3),
    .o_result (w_ext)
  );

  // Decode legality/alignment of the incoming access and the store lanes
  always_comb begin
    w_mem      = mem_rd_i | mem_wr_i;
    w_ld_ok    = (funct3_i == LB) || (funct3_i == LH) || (funct3_i == LW) ||
                 (funct3_i == LBU) || (funct3_i == LHU);
    w_st_ok    = (funct3_i == SB) || (funct3_i == SH) || (funct3_i == SW);
    w_illegal  = (mem_rd_i & mem_wr_i) | (mem_rd_i & ~w_ld_ok) | (mem_wr_i & ~w_st_ok);
    w_misalign = ((funct3_i[1:0] == 2'b01) && alu_result_i[0]) ||
                 ((funct3_i[1:0] == 2'b10) && (alu_result_i[1:0] != 2'b00));
    w_bad      = w_illegal | w_misalign;
    w_start    = s_flag_i & w_mem & ~w_bad;
    w_wstrb    = 4'b0000;
    w_wdata    = 32'h0;
    if (mem_wr_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          w_wstrb = 4'b0001 << alu_result_i[1:0];
          w_wdata = {4{store_data_i[7:0]}};
        end
        2'b01: begin
          w_wstrb = alu_result_i[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{store_data_i[15:0]}};
        end
        default: begin
          w_wstrb = 4'b1111;
          w_wdata = store_data_i;
        end
      endcase
    end
  end

  // Access FSM: latch on accept, wait for ack or timeout, present result once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rd      <= 5'd0;
      r_addr    <= 32'h0;
      r_f3      <= 3'd0;
      r_we      <= 1'b0;
      r_wstrb   <= 4'b0000;
      r_wdata   <= 32'h0;
      r_cnt     <= 16'd0;
      r_timeout <= 1'b0;
      r_result  <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_rd      <= rd_i;
            r_addr    <= alu_result_i;
            r_f3      <= funct3_i;
            r_we      <= mem_wr_i;
            r_wstrb   <= w_wstrb;
            r_wdata   <= w_wdata;
            r_cnt     <= 16'd0;
            r_timeout <= 1'b0;
            r_result  <= 32'h0;
            r_state   <= REQ;
          end
        end
        REQ: begin
          r_cnt <= r_cnt + 16'd1;
          // An ack on the final allowed cycle still wins over the timeout
          if (dmem_ack) begin
            if (!r_we) r_result <= w_ext;
            r_state <= DONE;
          end else if (r_cnt == TO_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stage outputs; gated by rst_n so everything reads zero during reset
  always_comb begin
    stall_o    = 1'b0;
    s_flag_o   = 1'b0;
    wb_en_o    = 1'b0;
    rd_o       = 5'd0;
    result_o   = 32'h0;
    fault_o    = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = 32'h0;
    dmem_wstrb = 4'b0000;
    dmem_wdata = 32'h0;
    if (rst_n) begin
      case (r_state)
        IDLE: begin
          stall_o = w_start;
          if (s_flag_i && !w_start) begin
            s_flag_o = 1'b1;
            rd_o     = rd_i;
            if (!w_mem) begin
              wb_en_o  = wb_en_i;
              result_o = alu_result_i;
            end else begin
              fault_o = 1'b1;
            end
          end
        end
        REQ: begin
          stall_o    = 1'b1;
          dmem_req   = 1'b1;
          dmem_we    = r_we;
          dmem_addr  = {r_addr[31:2], 2'b00};
          dmem_wstrb = r_wstrb;
          dmem_wdata = r_wdata;
        end
        DONE: begin
          s_flag_o = 1'b1;
          rd_o     = r_rd;
          result_o = r_result;
          wb_en_o  = ~r_we & ~r_timeout;
          fault_o  = r_timeout;
        end
        default: ;
      endcase
      if (rd_o == 5'd0) wb_en_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (ACK_TIMEOUT=4 to exercise the timeout).
module tb_mem_access_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_flag_i, wb_en_i, mem_rd_i, mem_wr_i;
  logic [4:0]  rd_i;
  logic [31:0] alu_result_i, store_data_i;
  logic [2:0]  funct3_i;
  logic        stall_o, s_flag_o, wb_en_o, fault_o;
  logic [4:0]  rd_o;
  logic [31:0] result_o;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;

  int n_vec = 0;
  int n_err = 0;
  int stall_cnt;
  int req_cnt;

  mem_access_stage #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .s_flag_i(s_flag_i), .wb_en_i(wb_en_i), .rd_i(rd_i),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i), .mem_rd_i(mem_rd_i),
    .mem_wr_i(mem_wr_i), .funct3_i(funct3_i), .stall_o(stall_o), .s_flag_o(s_flag_o),
    .wb_en_o(wb_en_o), .rd_o(rd_o), .result_o(result_o), .fault_o(fault_o),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] sd, input logic ld, input logic st, input logic [2:0] f3);
    s_flag_i = v; wb_en_i = we; rd_i = rd; alu_result_i = a;
    store_data_i = sd; mem_rd_i = ld; mem_wr_i = st; funct3_i = f3;
  endtask

  initial begin
    rst_n = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    drive(1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 3'd0);
    #2;
    chk("rst_sflag", {31'h0, s_flag_o}, 32'h0);
    chk("rst_stall", {31'h0, stall_o}, 32'h0);
    chk("rst_result", result_o, 32'h0);
    chk("rst_req", {31'h0, dmem_req}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;

    // ALU pass-through
    drive(1'b1, 1'b1, 5'd5, 32'h1234, 32'h0, 1'b0, 1'b0, 3'd0);
    #2;
    chk("alu_sflag", {31'h0, s_flag_o}, 32'h1);
    chk("alu_result", result_o, 32'h1234);
    chk("alu_rd_wb", {26'h0, rd_o, wb_en_o}, {26'h0, 5'd5, 1'b1});
    chk("alu_stall_req", {30'h0, stall_o, dmem_req}, 32'h0);
    drive(1'b1, 1'b1, 5'd0, 32'h55, 32'h0, 1'b0, 1'b0, 3'd0);
    #1;
    chk("alu_rd0_wb", {31'h0, wb_en_o}, 32'h0);
    drive(1'b0, 1'b1, 5'd5, 32'h55, 32'h0, 1'b0, 1'b0, 3'd0);
    #1;
    chk("bubble_sflag", {31'h0, s_flag_o}, 32'h0);

    // LB @0x103, ack after 3 wait cycles
    tick();
    drive(1'b1, 1'b1, 5'd7, 32'h103, 32'h0, 1'b1, 1'b0, LB);
    stall_cnt = 0;
    #2;
    if (stall_o) stall_cnt++;
    chk("lb_c0_sflag_req", {30'h0, s_flag_o, dmem_req}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin dmem_ack = 1'b1; dmem_rdata = 32'h80FF_0000; end
      #2;
      if (stall_o) stall_cnt++;
      chk("lb_req", {31'h0, dmem_req}, 32'h1);
      chk("lb_addr", dmem_addr, 32'h100);
    end
    tick();
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #2;
    if (stall_o) stall_cnt++;
    chk("lb_stall_cycles", stall_cnt, 32'd5);
    chk("lb_done_result", result_o, 32'hFFFF_FF80);
    chk("lb_done_flags", {29'h0, s_flag_o, wb_en_o, fault_o}, 32'b110);
    chk("lb_done_rd", {27'h0, rd_o}, 32'd7);

    // SH @0x202, ack in first REQ cycle
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'h202, 32'hABCD_1234, 1'b0, 1'b1, SH);
    #2;
    chk("sh_c0_stall", {31'h0, stall_o}, 32'h1);
    tick();
    dmem_ack = 1'b1;
    #2;
    chk("sh_we", {31'h0, dmem_we}, 32'h1);
    chk("sh_wdata", dmem_wdata, 32'h1234_1234);
    chk("sh_wstrb", {28'h0, dmem_wstrb}, 32'b1100);
    chk("sh_addr", dmem_addr, 32'h200);
    tick();
    dmem_ack = 1'b0;
    #2;
    chk("sh_done", {29'h0, s_flag_o, wb_en_o, stall_o}, 32'b100);

    // SB @0x5 lanes
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'h5, 32'h1122_335A, 1'b0, 1'b1, SB);
    tick();
    dmem_ack = 1'b1;
    #2;
    chk("sb_wstrb", {28'h0, dmem_wstrb}, 32'b0010);
    chk("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
    tick();
    dmem_ack = 1'b0;

    // Misaligned LW @0x2 and illegal accesses
    tick();
    drive(1'b1, 1'b1, 5'd3, 32'h2, 32'h0, 1'b1, 1'b0, LW);
    #2;
    chk("lw_mis", {27'h0, s_flag_o, wb_en_o, fault_o, stall_o, dmem_req}, 32'b10100);
    drive(1'b1, 1'b1, 5'd3, 32'h4, 32'h0, 1'b1, 1'b1, LW);
    #1;
    chk("rdwr_illegal", {28'h0, s_flag_o, wb_en_o, fault_o, stall_o}, 32'b1010);
    drive(1'b1, 1'b1, 5'd3, 32'h4, 32'h0, 1'b1, 1'b0, 3'b011);
    #1;
    chk("ld_f3_illegal", {28'h0, s_flag_o, fault_o, stall_o, dmem_req}, 32'b1100);
    drive(1'b1, 1'b0, 5'd3, 32'h4, 32'h0, 1'b0, 1'b1, LBU);
    #1;
    chk("st_f3_illegal", {30'h0, fault_o, stall_o}, 32'b10);
    tick();
    #1;
    chk("after_illegal_req", {31'h0, dmem_req}, 32'h0);

    // LW @0x10, never acked: timeout
    drive(1'b1, 1'b1, 5'd4, 32'h10, 32'h0, 1'b1, 1'b0, LW);
    req_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      #2;
      if (dmem_req) req_cnt++;
    end
    chk("to_req_cycles", req_cnt, 32'd4);
    tick();
    #2;
    chk("to_done", {27'h0, s_flag_o, wb_en_o, fault_o, stall_o, dmem_req}, 32'b10100);
    tick();
    drive(1'b1, 1'b1, 5'd6, 32'hCAFE, 32'h0, 1'b0, 1'b0, 3'd0);
    #2;
    chk("to_next_alu", {26'h0, s_flag_o, stall_o, fault_o, wb_en_o, 2'b0} | result_o[15:0] << 8,
        {16'h0, 16'hCAFE} << 8 | 32'b100100);

    // Reset mid-REQ, then fresh LBU
    tick();
    drive(1'b1, 1'b1, 5'd8, 32'h20, 32'h0, 1'b1, 1'b0, LW);
    tick();
    #1;
    chk("rst_pre_req", {31'h0, dmem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_req_drop", {31'h0, dmem_req}, 32'h0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 5'd9, 32'h41, 32'h0, 1'b1, 1'b0, LBU);
    #2;
    chk("lbu_accept", {30'h0, stall_o, s_flag_o}, 32'b10);
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'h0000_8000;
    #2;
    chk("lbu_addr", dmem_addr, 32'h40);
    tick();
    dmem_ack = 1'b0;
    #2;
    chk("lbu_result", result_o, 32'h0000_0080);
    chk("lbu_flags", {30'h0, s_flag_o, wb_en_o}, 32'b11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage between the EX/MEM register and the MEM/WB register. Non-memory instructions pass straight through. Loads and stores run a request/acknowledge transaction on the data-memory port, with byte and halfword alignment, write strobes, load sign/zero extension and a timeout. While a transaction is in progress, the stage stalls upstream and sends bubbles downstream.

## Interface
- ACK_TIMEOUT, 16: cycles to wait in REQ for dmem_ack before the access is aborted.
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- s_flag_i  in  1  instruction valid from EX/MEM
- wb_en_i  in  1  instruction writes rd
- rd_i  in  5  destination register
- alu_result_i  in  32  ALU result; also the effective address for memory ops
- store_data_i  in  32  rs2 value for stores
- mem_rd_i  in  1  load
- mem_wr_i  in  1  store
- funct3_i  in  3  access size and sign
- stall_o  out  1  upstream must hold all inputs stable
- s_flag_o  out  1  valid to MEM/WB
- wb_en_o  out  1  write-back enable to MEM/WB
- rd_o  out  5  destination to MEM/WB
- result_o  out  32  write-back data to MEM/WB
- fault_o  out  1  one-cycle pulse: misaligned, illegal or timed-out access
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  write request
- dmem_addr  out  32  word address, with bits [1:0] forced to 0
- dmem_wstrb  out  4  byte write strobes
- dmem_wdata  out  32  store data, replicated into lanes
- dmem_ack  in  1  request accepted/completed
- dmem_rdata  in  32  read word, valid with ack

## Operation
- FSM states: IDLE, REQ, DONE.
- Illegal access; both of these are handled exactly like a misaligned access (below):
  - mem_rd_i and mem_wr_i both set.
  - Load funct3 not in {000, 001, 010, 100, 101}.
  - Store funct3 not in {000, 001, 010}.
- IDLE, pass-through cases:
  - s_flag_i=0: s_flag_o=0, stall_o=0.
  - Non-memory op: s_flag_o=1, result_o=alu_result_i, rd_o=rd_i, wb_en_o=wb_en_i.
  - Misaligned access (halfword with addr[0]=1, word with addr[1:0]≠0) or illegal access:
    - No request is issued.
    - s_flag_o=1, wb_en_o=0, fault_o=1.
    - stall_o=0.
- IDLE, legal memory op:
  - Latch rd, address, funct3, direction, strobes and wdata.
  - stall_o=1, s_flag_o=0.
  - Go to REQ.
- REQ:
  - dmem_req=1 and all dmem_* outputs come from the latched values.
  - stall_o=1, s_flag_o=0.
  - The timeout counter increments each cycle.
  - On dmem_ack: capture the extended load data and go to DONE.
  - If the counter reaches ACK_TIMEOUT-1 without ack: drop the request, set the timeout flag, and go to DONE.
- DONE:
  - s_flag_o=1, stall_o=0, then return to IDLE.
  - Load: result_o is the captured data and wb_en_o=1.
  - Store: wb_en_o=0.
  - Timed-out access: wb_en_o=0 and fault_o=1.
- wb_en_o is forced to 0 whenever rd_o=0.
- Store lanes:
  - SB: wdata={4{b}}, wstrb=1<<addr[1:0].
  - SH: wdata={2{h}}, wstrb=addr[1] ? 1100 : 0011.
  - SW: wstrb=1111.
  - For loads, wstrb=0.
- Load extraction: select the byte by addr[1:0] or the halfword by addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.

## Timing
- All outputs are low or zero while rst_n=0; the state is IDLE.
- Reset asserted mid-transaction:
  - dmem_req drops immediately (asynchronously).
  - The access is lost and no DONE is produced.
- Outputs in IDLE are combinational from the inputs; MEM/WB registers them.
- Memory op with ack in the first REQ cycle:
  - Accepted in cycle 0, REQ in cycle 1, DONE in cycle 2.
  - That is 2 bubble cycles; the next instruction is accepted in cycle 3.
  - Each extra wait cycle adds 1.
- dmem_req, dmem_we, dmem_addr, dmem_wstrb and dmem_wdata stay stable in REQ until ack.
- Memory must not ack when dmem_req=0. An ack seen outside REQ is ignored.
- The timeout counter clears on entry to REQ.
- The counter is 16 bits; ACK_TIMEOUT must be at least 2.

## Structure
- The shared riscv_pkg holds:
  - The funct3 load/store constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - The mem_state_t enum for IDLE, REQ, DONE.
- One combinational sub-module, load_extend, takes (rdata, addr[1:0], funct3) and returns the 32-bit extended value.
- The FSM, latches and store-lane logic live in the top module.

## Test plan
- ALU op, alu_result_i=0x1234, rd=5, wb_en=1 -> same cycle: s_flag_o=1, result_o=0x1234, stall_o=0, no dmem_req.
- LB at addr 0x103, rdata=0x80FF_0000, ack after 3 wait cycles:
  - stall_o high for 5 cycles.
  - DONE gives result_o=0xFFFF_FF80, wb_en_o=1.
  - dmem_addr=0x100 throughout REQ.
- SH at addr 0x202, store_data=0xABCD_1234 -> dmem_we=1, wdata=0x1234_1234, wstrb=1100; DONE has wb_en_o=0.
- LW at addr 0x2 -> no dmem_req, fault_o=1, s_flag_o=1, wb_en_o=0, no stall.
- Load with ACK_TIMEOUT=4 and ack never given:
  - dmem_req high for 4 cycles, then DONE with fault_o=1, wb_en_o=0.
  - A following instruction proceeds normally.
- rst_n pulsed low during REQ -> dmem_req=0 immediately; after release, state is IDLE and a fresh LBU of 0x80 returns 0x0000_0080.
